// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR Fibonacci LFSR generator and checker:
// per-width tap table, next-state function and checker state encodings.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Tap bit k (numbered 1..width) is bit k-1 of the returned mask.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // Shift left and insert the XNOR of the tap bits; all-ones maps to itself.
  function automatic logic [31:0] lfsr_next(input int width, input logic [31:0] state);
    logic [31:0] mask;
    logic        fb;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    fb   = ~^(state & lfsr_taps(width));
    return ((state << 1) | {31'b0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational LFSR next-state, shared by generator and checker so the
// two ends of a link always agree on the sequence.
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS = 11
) (
  input  logic [NUM_BITS-1:0] state,
  output logic [NUM_BITS-1:0] next_state
);

  assign next_state = NUM_BITS'(lfsr_next(NUM_BITS, 32'(state)));

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the XNOR LFSR word stream: acquires lock,
// flywheels its own prediction, and flags/counts mispredicted words.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 11,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Clear,
  input  logic                 i_Valid,
  input  logic [NUM_BITS-1:0]  i_Data,
  output logic                 o_Locked,
  output logic                 o_Error,
  output logic                 o_Lockup,
  output logic [CNT_WIDTH-1:0] o_Err_Count,
  output logic [CNT_WIDTH-1:0] o_Word_Count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  chk_state_t           state, state_nxt;
  logic [NUM_BITS-1:0]  ref_word, ref_nxt, pred;
  logic [MATCH_W-1:0]   match_cnt, match_nxt;
  logic [MISS_W-1:0]    miss_cnt, miss_nxt;
  logic                 error_nxt, lockup_nxt;
  logic [CNT_WIDTH-1:0] err_cnt_nxt, word_cnt_nxt;
  logic                 all_ones, hit;

  lfsr_next_state #(
    .NUM_BITS (NUM_BITS)
  ) u_next (
    .state      (ref_word),
    .next_state (pred)
  );

  assign all_ones = &i_Data;
  assign hit      = (i_Data == pred);

  always_comb begin
    state_nxt    = state;
    ref_nxt      = ref_word;
    match_nxt    = match_cnt;
    miss_nxt     = miss_cnt;
    error_nxt    = 1'b0;
    lockup_nxt   = 1'b0;
    err_cnt_nxt  = o_Err_Count;
    word_cnt_nxt = o_Word_Count;

    if (i_Clear) begin
      state_nxt    = HUNT;
      ref_nxt      = '0;
      match_nxt    = '0;
      miss_nxt     = '0;
      err_cnt_nxt  = '0;
      word_cnt_nxt = '0;
    end else if (i_Valid) begin
      lockup_nxt = all_ones;
      case (state)
        HUNT: begin
          if (!all_ones) begin
            ref_nxt   = i_Data;
            match_nxt = '0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          ref_nxt = i_Data;
          if (all_ones) begin
            match_nxt = '0;
            state_nxt = HUNT;
          end else if (hit) begin
            match_nxt = match_cnt + MATCH_W'(1);
            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
              miss_nxt  = '0;
              state_nxt = LOCKED;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so a single corrupted word costs one error.
          ref_nxt      = pred;
          word_cnt_nxt = sat_inc(o_Word_Count);
          if (hit) begin
            miss_nxt = '0;
          end else begin
            error_nxt   = 1'b1;
            err_cnt_nxt = sat_inc(o_Err_Count);
            miss_nxt    = miss_cnt + MISS_W'(1);
            if (miss_cnt == MISS_W'(LOSS_COUNT - 1)) begin
              state_nxt = HUNT;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= HUNT;
      ref_word     <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      o_Locked     <= 1'b0;
      o_Error      <= 1'b0;
      o_Lockup     <= 1'b0;
      o_Err_Count  <= '0;
      o_Word_Count <= '0;
    end else begin
      state        <= state_nxt;
      ref_word     <= ref_nxt;
      match_cnt    <= match_nxt;
      miss_cnt     <= miss_nxt;
      o_Locked     <= (state_nxt == LOCKED);
      o_Error      <= error_nxt;
      o_Lockup     <= lockup_nxt;
      o_Err_Count  <= err_cnt_nxt;
      o_Word_Count <= word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: two instances (16-bit and 2-bit counters)
// share one directed stimulus stream against hand-computed expectations.
`timescale 1ns/1ps
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] data = '0;

  logic        locked_a, error_a, lockup_a;
  logic [15:0] ecnt_a, wcnt_a;
  logic        locked_b, error_b, lockup_b;
  logic [1:0]  ecnt_b, wcnt_b;

  always #5 clk = ~clk;

  lfsr_checker #(.NUM_BITS(11), .LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_WIDTH(16)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clear), .i_Valid(valid), .i_Data(data),
    .o_Locked(locked_a), .o_Error(error_a), .o_Lockup(lockup_a),
    .o_Err_Count(ecnt_a), .o_Word_Count(wcnt_a)
  );

  lfsr_checker #(.NUM_BITS(11), .LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_WIDTH(2)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clear), .i_Valid(valid), .i_Data(data),
    .o_Locked(locked_b), .o_Error(error_b), .o_Lockup(lockup_b),
    .o_Err_Count(ecnt_b), .o_Word_Count(wcnt_b)
  );

  // Generator sequence from seed 0x001, worked out by hand (taps 11,9).
  localparam logic [10:0] G [0:22] = '{
    11'h001, 11'h003, 11'h007, 11'h00F, 11'h01F, 11'h03F, 11'h07F, 11'h0FF,
    11'h1FF, 11'h3FE, 11'h7FC, 11'h7F9, 11'h7F3, 11'h7E7, 11'h7CF, 11'h79F,
    11'h73F, 11'h67F, 11'h4FE, 11'h1FC, 11'h3F8, 11'h7F0, 11'h7E1
  };

  typedef struct {
    int   idx;
    logic locked;
    logic err;
    logic lockup;
    int   ecnt;
    int   wcnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [entry %0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic push(input logic lk, input logic er, input logic lu, input int ec, input int wc);
    exp_t e;
    e.idx = n_push; e.locked = lk; e.err = er; e.lockup = lu; e.ecnt = ec; e.wcnt = wc;
    q.push_back(e);
    n_push++;
  endtask

  task automatic send(input logic [10:0] d, input logic lk, input logic er, input logic lu,
                      input int ec, input int wc);
    @(negedge clk);
    valid = 1'b1; clear = 1'b0; data = d;
    push(lk, er, lu, ec, wc);
  endtask

  task automatic idle(input logic lk, input int ec, input int wc);
    @(negedge clk);
    valid = 1'b0; clear = 1'b0;
    push(lk, 1'b0, 1'b0, ec, wc);
  endtask

  task automatic clear_with_word(input logic [10:0] d);
    @(negedge clk);
    valid = 1'b1; clear = 1'b1; data = d;
    push(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, -1, int'(locked_a), 0);
    check({tag, "_error"},  -1, int'(error_a),  0);
    check({tag, "_lockup"}, -1, int'(lockup_a), 0);
    check({tag, "_ecnt"},   -1, int'(ecnt_a),   0);
    check({tag, "_wcnt"},   -1, int'(wcnt_a),   0);
    check({tag, "_wcnt_b"}, -1, int'(wcnt_b),   0);
  endtask

  // Monitor: each entry describes the outputs one edge after it was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() != 0) begin
        @(negedge clk);
        e = q.pop_front();
        check("locked",   e.idx, int'(locked_a), int'(e.locked));
        check("error",    e.idx, int'(error_a),  int'(e.err));
        check("lockup",   e.idx, int'(lockup_a), int'(e.lockup));
        check("err_cnt",  e.idx, int'(ecnt_a),   e.ecnt);
        check("word_cnt", e.idx, int'(wcnt_a),   e.wcnt);
        check("locked_b", e.idx, int'(locked_b), int'(e.locked));
        check("error_b",  e.idx, int'(error_b),  int'(e.err));
        check("lockup_b", e.idx, int'(lockup_b), int'(e.lockup));
        check("err_cnt_b",  e.idx, int'(ecnt_b), sat3(e.ecnt));
        check("word_cnt_b", e.idx, int'(wcnt_b), sat3(e.wcnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d entries pending", q.size());
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;

    // Acquisition with idle gaps; lock follows the ninth word.
    send(G[0], 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    send(G[1], 0, 0, 0, 0, 0);
    send(G[2], 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    for (int i = 3; i <= 7; i++) send(G[i], 0, 0, 0, 0, 0);
    send(G[8], 1, 0, 0, 0, 0);

    // Single corrupted word, then correct continuation; isolated errors.
    send(11'h3FF, 1, 1, 0, 1, 1);
    idle(1, 1, 1);
    send(G[10], 1, 0, 0, 1, 2);
    send(G[11], 1, 0, 0, 1, 3);
    send(G[12], 1, 0, 0, 1, 4);
    send(11'h000, 1, 1, 0, 2, 5);
    send(G[14], 1, 0, 0, 2, 6);
    send(11'h000, 1, 1, 0, 3, 7);
    send(G[16], 1, 0, 0, 3, 8);
    send(11'h000, 1, 1, 0, 4, 9);
    send(G[18], 1, 0, 0, 4, 10);

    // Four consecutive misses drop lock; a fifth is not counted.
    send(11'h000, 1, 1, 0, 5, 11);
    send(11'h000, 1, 1, 0, 6, 12);
    send(11'h000, 1, 1, 0, 7, 13);
    send(11'h000, 0, 1, 0, 8, 14);
    send(11'h000, 0, 0, 0, 8, 14);

    // All-ones in SYNC, then in HUNT.
    send(11'h7FF, 0, 0, 1, 8, 14);
    send(11'h7FF, 0, 0, 1, 8, 14);

    // Reacquire (counters held), then clear with a valid word.
    for (int i = 0; i <= 7; i++) send(G[i], 0, 0, 0, 8, 14);
    send(G[8], 1, 0, 0, 8, 14);
    send(G[9], 1, 0, 0, 8, 15);
    clear_with_word(G[10]);
    for (int i = 11; i <= 18; i++) send(G[i], 0, 0, 0, 0, 0);
    send(G[19], 1, 0, 0, 0, 0);

    // Asynchronous reset between edges while locked.
    send(G[20], 1, 0, 0, 0, 1);
    idle(1, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    #1 rst_n = 1'b1;
    send(G[21], 0, 0, 0, 0, 0);
    send(G[22], 0, 0, 0, 0, 0);

    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", -1, q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side counterpart to the team's XNOR Fibonacci LFSR generator.
- Consumes the generator's parallel word stream, one word per generator shift, and self-synchronises to it.
- Flywheels a local copy of the sequence once synchronised, and flags and counts mismatching words.
- Used for link/BIST checking of pseudo-random streams and to detect generator lockup, all-ones being the XNOR lock state.

Parameters:
- NUM_BITS, 11, LFSR width; legal 3..32, same tap table as the generator.
- LOCK_COUNT, 8, consecutive correct predictions required to declare lock.
- LOSS_COUNT, 4, consecutive mispredictions in LOCKED that drop lock.
- CNT_WIDTH, 16, width of the saturating error and word counters.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst_L  in  1  async active-low reset.
- i_Clear  in  1  sync: zero counters, return to HUNT.
- i_Valid  in  1  i_Data holds a new word this cycle.
- i_Data  in  NUM_BITS  received LFSR word.
- o_Locked  out  1  checker is in LOCKED.
- o_Error  out  1  1-cycle pulse: last valid word mispredicted while LOCKED.
- o_Lockup  out  1  1-cycle pulse: last valid word was all-ones.
- o_Err_Count  out  CNT_WIDTH  saturating count of mispredicted words while LOCKED.
- o_Word_Count  out  CNT_WIDTH  saturating count of valid words checked while LOCKED.

Behaviour:
- Next-state function, state bits numbered 1..NUM_BITS: next(s) = {s[NUM_BITS-1:1], fb}, where fb is the XNOR of the tap bits.
  - Taps are identical per width to the generator, e.g. 11: bits 11,9; 8: bits 8,6,5,4.
- Reset (i_Rst_L low, async) forces:
  - state HUNT;
  - all outputs 0;
  - internal registers r_Ref, r_Match, r_Miss = 0.
- Priority each cycle: reset > i_Clear > i_Valid. i_Clear with i_Valid discards the word.
- When i_Valid is low: no state, counter or pulse change, and pulses deassert.
- All outputs are registered. Every response appears the cycle after the i_Valid word.
- o_Lockup pulses for any valid all-ones word, in every state.
- HUNT:
  - Valid word that is not all-ones: r_Ref <= data, r_Match <= 0, go to SYNC.
  - All-ones word: stay in HUNT.
- SYNC:
  - Valid word equal to next(r_Ref): r_Match+1.
  - Valid word not equal: r_Match <= 0.
  - r_Ref <= data in both cases (self-synchronising).
  - All-ones word: go to HUNT.
  - When r_Match reaches LOCK_COUNT: go to LOCKED, r_Miss <= 0, o_Locked=1 the following cycle.
- LOCKED:
  - Expected word = next(r_Ref), and r_Ref <= expected whether or not the word matches. The checker flywheels on its own prediction, so one corrupted word counts one error.
  - o_Word_Count+1 on every valid word.
  - Match: r_Miss <= 0.
  - Mismatch: o_Error pulse, o_Err_Count+1, r_Miss+1.
  - When r_Miss reaches LOSS_COUNT: go to HUNT, o_Locked=0. Counters hold their values.
- Counters saturate at all-ones and never wrap.
- Reset mid-stream returns to HUNT immediately; the next valid word starts re-acquisition.

Decomposition:
- Shared package lfsr_pkg holds:
  - the tap table / feedback function lfsr_next(width, state), which the generator also uses;
  - state encodings HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2.
- One combinational sub-module, lfsr_next_state (param NUM_BITS), computes next(s). It is shared with the generator so both ends cannot diverge.

Test Plan:
NUM_BITS=11, LOCK_COUNT=8, LOSS_COUNT=4. Generator sequence from seed 0x001 is 001,003,007,00F,01F,03F,07F,0FF,1FF,3FE,…
1. Reset: assert i_Rst_L low mid-LOCKED, asynchronously between edges -> all outputs 0 immediately, next word 0x001 moves to SYNC only.
2. Acquisition: valid words 001..1FF (9 words, back-to-back and with idle gaps) -> o_Locked rises the cycle after 0x1FF; o_Error never pulses.
3. Single error: while locked, send 0x3FF instead of 0x3FE, then the correct continuation -> one o_Error pulse, o_Err_Count=1, o_Locked stays 1, following words match.
4. Loss of lock: while locked, send 4 consecutive wrong words -> 4 error pulses, o_Err_Count=4, o_Locked falls the cycle after the 4th. A 5th wrong word is not counted.
5. Lockup: send 0x7FF in HUNT and again in SYNC -> o_Lockup pulse each time, state HUNT after each.
6. i_Clear with i_Valid in the same cycle while locked -> counters 0, HUNT, word ignored. With CNT_WIDTH=2, 5 errors in LOCKED -> o_Err_Count saturates at 3.
